// File: rtl/regfile_rename_pkg.sv
// rtl/regfile_rename_pkg.sv - shared widths and constants for the rename register file
package regfile_rename_pkg;

    localparam int REG_W  = 5;
    localparam int ROB_W  = 5;
    localparam int INST_W = 32;

    // The ROB also treats index 0 as "unused", so tag 0 means no producer.
    localparam logic [ROB_W-1:0]  ROB_TAG_NONE = '0;
    localparam logic [INST_W-1:0] NULL_VALUE   = '0;
    localparam logic              BUSY         = 1'b1;
    localparam logic              IDLE         = 1'b0;

endpackage

// File: rtl/regfile_rename_read_port.sv
// rtl/regfile_rename_read_port.sv - one operand lookup: x0, busy and optional commit bypass (REGFILE_COMMIT_BYPASS_EN)
module regfile_read_port
    import regfile_rename_pkg::*;
(
    input  logic [REG_W-1:0]  rs,
    input  logic              reg_busy,
    input  logic [ROB_W-1:0]  reg_tag,
    input  logic [INST_W-1:0] reg_value,
`ifdef REGFILE_COMMIT_BYPASS_EN
    input  logic              commit_en,
    input  logic [REG_W-1:0]  commit_reg,
    input  logic [ROB_W-1:0]  commit_dest,
    input  logic [INST_W-1:0] commit_value,
`endif
    output logic              busy,
    output logic [ROB_W-1:0]  tag,
    output logic [INST_W-1:0] data
);

    always_comb begin
        busy = IDLE;
        tag  = ROB_TAG_NONE;
        data = NULL_VALUE;
        if (rs != '0) begin
            if (reg_busy) begin
                busy = BUSY;
                tag  = reg_tag;
                data = NULL_VALUE;
`ifdef REGFILE_COMMIT_BYPASS_EN
                // The producer is retiring this very cycle: hand its value over now.
                if (commit_en && commit_reg == rs && commit_dest == reg_tag) begin
                    busy = IDLE;
                    tag  = ROB_TAG_NONE;
                    data = commit_value;
                end
`endif
            end else begin
                data = reg_value;
            end
        end
    end

endmodule

// File: rtl/regfile_rename.sv
// rtl/regfile_rename.sv - architectural register file with ROB rename tags (option: REGFILE_COMMIT_BYPASS_EN)
module regfile_rename
    import regfile_rename_pkg::*;
#(
    parameter int REG_NUM = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              dispatcher_en_in,
    input  logic [REG_W-1:0]  dispatcher_rd_in,
    input  logic [ROB_W-1:0]  dispatcher_dest_in,
    input  logic [REG_W-1:0]  dispatcher_rs1_in,
    input  logic [REG_W-1:0]  dispatcher_rs2_in,
    output logic              dispatcher_rs1_busy_out,
    output logic [ROB_W-1:0]  dispatcher_rs1_tag_out,
    output logic [INST_W-1:0] dispatcher_rs1_data_out,
    output logic              dispatcher_rs2_busy_out,
    output logic [ROB_W-1:0]  dispatcher_rs2_tag_out,
    output logic [INST_W-1:0] dispatcher_rs2_data_out,
    input  logic              rob_commit_en_in,
    input  logic [REG_W-1:0]  rob_commit_reg_pos_in,
    input  logic [ROB_W-1:0]  rob_commit_dest_in,
    input  logic [INST_W-1:0] rob_commit_value_in
);

    logic [INST_W-1:0] value_q [REG_NUM];
    logic              busy_q  [REG_NUM];
    logic [ROB_W-1:0]  tag_q   [REG_NUM];

    // Later assignments win: flush beats commit-clear, dispatch beats commit-clear.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                busy_q[i]  <= IDLE;
                tag_q[i]   <= ROB_TAG_NONE;
            end
        end else if (rdy_in) begin
            if (rob_commit_en_in && rob_commit_reg_pos_in != '0) begin
                value_q[rob_commit_reg_pos_in] <= rob_commit_value_in;
                if (tag_q[rob_commit_reg_pos_in] == rob_commit_dest_in) begin
                    busy_q[rob_commit_reg_pos_in] <= IDLE;
                    tag_q[rob_commit_reg_pos_in]  <= ROB_TAG_NONE;
                end
            end
            if (flush_in) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    busy_q[i] <= IDLE;
                    tag_q[i]  <= ROB_TAG_NONE;
                end
            end else if (dispatcher_en_in && dispatcher_rd_in != '0) begin
                busy_q[dispatcher_rd_in] <= BUSY;
                tag_q[dispatcher_rd_in]  <= dispatcher_dest_in;
            end
        end
    end

    regfile_read_port u_rs1 (
        .rs           (dispatcher_rs1_in),
        .reg_busy     (busy_q[dispatcher_rs1_in]),
        .reg_tag      (tag_q[dispatcher_rs1_in]),
        .reg_value    (value_q[dispatcher_rs1_in]),
`ifdef REGFILE_COMMIT_BYPASS_EN
        .commit_en    (rob_commit_en_in),
        .commit_reg   (rob_commit_reg_pos_in),
        .commit_dest  (rob_commit_dest_in),
        .commit_value (rob_commit_value_in),
`endif
        .busy         (dispatcher_rs1_busy_out),
        .tag          (dispatcher_rs1_tag_out),
        .data         (dispatcher_rs1_data_out)
    );

    regfile_read_port u_rs2 (
        .rs           (dispatcher_rs2_in),
        .reg_busy     (busy_q[dispatcher_rs2_in]),
        .reg_tag      (tag_q[dispatcher_rs2_in]),
        .reg_value    (value_q[dispatcher_rs2_in]),
`ifdef REGFILE_COMMIT_BYPASS_EN
        .commit_en    (rob_commit_en_in),
        .commit_reg   (rob_commit_reg_pos_in),
        .commit_dest  (rob_commit_dest_in),
        .commit_value (rob_commit_value_in),
`endif
        .busy         (dispatcher_rs2_busy_out),
        .tag          (dispatcher_rs2_tag_out),
        .data         (dispatcher_rs2_data_out)
    );

endmodule

// File: tb/tb_regfile_rename.sv
// tb/tb_regfile_rename.sv - table-driven bench for regfile_rename
module tb_regfile_rename;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        dispatcher_en_in;
    logic [4:0]  dispatcher_rd_in;
    logic [4:0]  dispatcher_dest_in;
    logic [4:0]  dispatcher_rs1_in;
    logic [4:0]  dispatcher_rs2_in;
    logic        dispatcher_rs1_busy_out;
    logic [4:0]  dispatcher_rs1_tag_out;
    logic [31:0] dispatcher_rs1_data_out;
    logic        dispatcher_rs2_busy_out;
    logic [4:0]  dispatcher_rs2_tag_out;
    logic [31:0] dispatcher_rs2_data_out;
    logic        rob_commit_en_in;
    logic [4:0]  rob_commit_reg_pos_in;
    logic [4:0]  rob_commit_dest_in;
    logic [31:0] rob_commit_value_in;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    regfile_rename dut (
        .clk_in                  (clk_in),
        .rst_in                  (rst_in),
        .rdy_in                  (rdy_in),
        .flush_in                (flush_in),
        .dispatcher_en_in        (dispatcher_en_in),
        .dispatcher_rd_in        (dispatcher_rd_in),
        .dispatcher_dest_in      (dispatcher_dest_in),
        .dispatcher_rs1_in       (dispatcher_rs1_in),
        .dispatcher_rs2_in       (dispatcher_rs2_in),
        .dispatcher_rs1_busy_out (dispatcher_rs1_busy_out),
        .dispatcher_rs1_tag_out  (dispatcher_rs1_tag_out),
        .dispatcher_rs1_data_out (dispatcher_rs1_data_out),
        .dispatcher_rs2_busy_out (dispatcher_rs2_busy_out),
        .dispatcher_rs2_tag_out  (dispatcher_rs2_tag_out),
        .dispatcher_rs2_data_out (dispatcher_rs2_data_out),
        .rob_commit_en_in        (rob_commit_en_in),
        .rob_commit_reg_pos_in   (rob_commit_reg_pos_in),
        .rob_commit_dest_in      (rob_commit_dest_in),
        .rob_commit_value_in     (rob_commit_value_in)
    );

    typedef struct {
        logic        rdy;
        logic        flush;
        logic        den;
        logic [4:0]  rd;
        logic [4:0]  ddest;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        cen;
        logic [4:0]  cpos;
        logic [4:0]  cdest;
        logic [31:0] cval;
        logic        e1b;
        logic [4:0]  e1t;
        logic [31:0] e1d;
        logic        e2b;
        logic [4:0]  e2t;
        logic [31:0] e2d;
    } vec_t;

    vec_t vecs[$];

`ifdef REGFILE_COMMIT_BYPASS_EN
    localparam logic        BYP_B = 1'b0;
    localparam logic [4:0]  BYP_T = 5'd0;
    localparam logic [31:0] BYP_D = 32'h55;
`else
    localparam logic        BYP_B = 1'b1;
    localparam logic [4:0]  BYP_T = 5'd4;
    localparam logic [31:0] BYP_D = 32'h0;
`endif

    function automatic vec_t mk(logic rdy, logic flush, logic den, logic [4:0] rd, logic [4:0] ddest,
                                logic [4:0] rs1, logic [4:0] rs2, logic cen, logic [4:0] cpos,
                                logic [4:0] cdest, logic [31:0] cval,
                                logic e1b, logic [4:0] e1t, logic [31:0] e1d,
                                logic e2b, logic [4:0] e2t, logic [31:0] e2d);
        vec_t v;
        v.rdy = rdy; v.flush = flush; v.den = den; v.rd = rd; v.ddest = ddest;
        v.rs1 = rs1; v.rs2 = rs2; v.cen = cen; v.cpos = cpos; v.cdest = cdest; v.cval = cval;
        v.e1b = e1b; v.e1t = e1t; v.e1d = e1d; v.e2b = e2b; v.e2t = e2t; v.e2d = e2d;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ports(input string tagname, input logic b1, input logic [4:0] t1, input logic [31:0] d1,
                               input logic b2, input logic [4:0] t2, input logic [31:0] d2);
        check({tagname, " rs1_busy"}, {31'd0, dispatcher_rs1_busy_out}, {31'd0, b1});
        check({tagname, " rs1_tag"},  {27'd0, dispatcher_rs1_tag_out},  {27'd0, t1});
        check({tagname, " rs1_data"}, dispatcher_rs1_data_out, d1);
        check({tagname, " rs2_busy"}, {31'd0, dispatcher_rs2_busy_out}, {31'd0, b2});
        check({tagname, " rs2_tag"},  {27'd0, dispatcher_rs2_tag_out},  {27'd0, t2});
        check({tagname, " rs2_data"}, dispatcher_rs2_data_out, d2);
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; flush_in = 1'b0; dispatcher_en_in = 1'b0;
        dispatcher_rd_in = '0; dispatcher_dest_in = '0;
        dispatcher_rs1_in = '0; dispatcher_rs2_in = '0;
        rob_commit_en_in = 1'b0; rob_commit_reg_pos_in = '0;
        rob_commit_dest_in = '0; rob_commit_value_in = '0;
    endtask

    initial begin
        //            rdy fl den rd  dd  rs1 rs2 cen cp  cd  cval          e1b e1t e1d          e2b e2t e2d
        vecs.push_back(mk(1, 0, 0, 0,  0,  7,  0,  1,  7,  3,  32'h1234,      0, 0,  32'h0,       0, 0,  32'h0));
        vecs.push_back(mk(1, 0, 1, 5,  4,  7,  0,  0,  0,  0,  32'h0,         0, 0,  32'h1234,    0, 0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0,  5,  7,  0,  0,  0,  32'h0,         1, 4,  32'h0,       0, 0,  32'h1234));
        vecs.push_back(mk(1, 0, 0, 0,  0,  7,  0,  1,  5,  4,  32'hAA,        0, 0,  32'h1234,    0, 0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0,  5,  0,  0,  0,  0,  32'h0,         0, 0,  32'hAA,      0, 0,  32'h0));
        vecs.push_back(mk(1, 0, 1, 5,  4,  0,  0,  0,  0,  0,  32'h0,         0, 0,  32'h0,       0, 0,  32'h0));
        // rs1 == rd in the same dispatch sees the old mapping
        vecs.push_back(mk(1, 0, 1, 5,  6,  5,  0,  0,  0,  0,  32'h0,         1, 4,  32'h0,       0, 0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0,  5,  0,  1,  5,  4,  32'h1,         1, 6,  32'h0,       0, 0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0,  5,  0,  0,  0,  0,  32'h0,         1, 6,  32'h0,       0, 0,  32'h0));
        vecs.push_back(mk(1, 0, 1, 5,  9,  7,  7,  1,  5,  6,  32'h2,         0, 0,  32'h1234,    0, 0,  32'h1234));
        vecs.push_back(mk(1, 0, 0, 0,  0,  5,  0,  0,  0,  0,  32'h0,         1, 9,  32'h0,       0, 0,  32'h0));
        vecs.push_back(mk(1, 0, 1, 3,  10, 0,  0,  0,  0,  0,  32'h0,         0, 0,  32'h0,       0, 0,  32'h0));
        vecs.push_back(mk(1, 0, 1, 4,  11, 0,  0,  0,  0,  0,  32'h0,         0, 0,  32'h0,       0, 0,  32'h0));
        // flush + JAL link commit + discarded dispatch
        vecs.push_back(mk(1, 1, 1, 8,  2,  3,  4,  1,  1,  12, 32'h104,       1, 10, 32'h0,       1, 11, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0,  1,  8,  0,  0,  0,  32'h0,         0, 0,  32'h104,     0, 0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0,  3,  5,  0,  0,  0,  32'h0,         0, 0,  32'h0,       0, 0,  32'h2));
        vecs.push_back(mk(1, 0, 0, 0,  0,  4,  0,  0,  0,  0,  32'h0,         0, 0,  32'h0,       0, 0,  32'h0));
        // stalled cycle loses its requests
        vecs.push_back(mk(0, 1, 1, 6,  7,  0,  0,  1,  7,  3,  32'hDEAD,      0, 0,  32'h0,       0, 0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0,  6,  7,  0,  0,  0,  32'h0,         0, 0,  32'h0,       0, 0,  32'h1234));
        vecs.push_back(mk(1, 0, 1, 0,  5,  0,  0,  1,  0,  5,  32'hFFFF,      0, 0,  32'h0,       0, 0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0,  0,  5,  0,  0,  0,  32'h0,         0, 0,  32'h0,       0, 0,  32'h2));
        vecs.push_back(mk(1, 0, 1, 5,  4,  0,  0,  0,  0,  0,  32'h0,         0, 0,  32'h0,       0, 0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0,  5,  0,  1,  5,  4,  32'h55,        BYP_B, BYP_T, BYP_D, 0, 0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0,  0,  5,  0,  0,  0,  0,  32'h0,         0, 0,  32'h55,      0, 0,  32'h0));

        idle_inputs();
        rst_in = 1'b0;
        dispatcher_rs1_in = 5'd7;
        dispatcher_rs2_in = 5'd1;
        #12;
        check_ports("reset", 0, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_in);
            rdy_in                = vecs[i].rdy;
            flush_in              = vecs[i].flush;
            dispatcher_en_in      = vecs[i].den;
            dispatcher_rd_in      = vecs[i].rd;
            dispatcher_dest_in    = vecs[i].ddest;
            dispatcher_rs1_in     = vecs[i].rs1;
            dispatcher_rs2_in     = vecs[i].rs2;
            rob_commit_en_in      = vecs[i].cen;
            rob_commit_reg_pos_in = vecs[i].cpos;
            rob_commit_dest_in    = vecs[i].cdest;
            rob_commit_value_in   = vecs[i].cval;
            #1;
            check_ports($sformatf("vec%0d", i), vecs[i].e1b, vecs[i].e1t, vecs[i].e1d,
                        vecs[i].e2b, vecs[i].e2t, vecs[i].e2d);
        end

        // Asynchronous reset mid-cycle overrides a pending commit and dispatch.
        @(negedge clk_in);
        idle_inputs();
        dispatcher_rs1_in = 5'd5;
        dispatcher_rs2_in = 5'd1;
        dispatcher_en_in = 1'b1; dispatcher_rd_in = 5'd9; dispatcher_dest_in = 5'd3;
        rob_commit_en_in = 1'b1; rob_commit_reg_pos_in = 5'd5;
        rob_commit_dest_in = 5'd0; rob_commit_value_in = 32'h77;
        #1;
        check_ports("pre_async_rst", 0, 0, 32'h55, 0, 0, 32'h104);
        #1;
        rst_in = 1'b0;
        #1;
        check_ports("async_rst", 0, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;
        idle_inputs();
        dispatcher_rs1_in = 5'd5;
        dispatcher_rs2_in = 5'd9;
        @(negedge clk_in);
        check_ports("post_rst", 0, 0, 32'h0, 0, 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_rename.md
# regfile_rename

Architectural register file with per-register ROB rename tags, sitting directly downstream of the ROB commit port and beside the dispatcher. It does three things:
- Serves rs1/rs2 operand lookups to the dispatcher, returning either a committed value or the ROB tag that will produce it.
- Records new rd→ROB-tag mappings at dispatch.
- Retires values on ROB commit and drops all in-flight mappings on flush.

## Interface
Parameters:
- REG_NUM, 32, architectural register count; x0 hardwired to zero.
- ROB_TAG_NONE, 0, tag value meaning "no producer"; valid ROB tags are 1..31.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  reset; asynchronous, active-low; clears all state immediately.
- rdy_in  input  1  global stall; when 0, no state updates occur, lookups stay live.
- flush_in  input  1  mispredict/jump flush from ROB.
- dispatcher_en_in  input  1  dispatch of an instruction this cycle.
- dispatcher_rd_in  input  `REGISTER_WIDTH  destination register.
- dispatcher_dest_in  input  `ROB_WIDTH  ROB tag allocated to the instruction.
- dispatcher_rs1_in  input  `REGISTER_WIDTH  source register 1.
- dispatcher_rs2_in  input  `REGISTER_WIDTH  source register 2.
- dispatcher_rs1_busy_out  output  1  1 means rs1 is pending on a ROB entry.
- dispatcher_rs1_tag_out  output  `ROB_WIDTH  producer tag; ROB_TAG_NONE when not busy.
- dispatcher_rs1_data_out  output  `INSTRUCTION_WIDTH  value; `NULL when busy.
- dispatcher_rs2_busy_out, dispatcher_rs2_tag_out, dispatcher_rs2_data_out  output  same meaning as the rs1 set, for rs2.
- rob_commit_en_in  input  1  commit write from ROB.
- rob_commit_reg_pos_in  input  `REGISTER_WIDTH  register being committed.
- rob_commit_dest_in  input  `ROB_WIDTH  ROB tag of the committing entry.
- rob_commit_value_in  input  `INSTRUCTION_WIDTH  committed value.

## Operation
Per-register state:
- value[31:0]
- busy
- tag[`ROB_WIDTH]

Commit, when rdy_in=1 and rob_commit_en_in=1 with reg_pos≠0:
- value[reg_pos] ← rob_commit_value_in.
- If tag[reg_pos] equals rob_commit_dest_in, clear busy and set tag to ROB_TAG_NONE.
- Otherwise, a younger producer exists and the mapping is kept.

Dispatch, when rdy_in=1, dispatcher_en_in=1, rd≠0 and flush_in=0:
- busy[rd] ← 1 and tag[rd] ← dispatcher_dest_in.

Commit and dispatch in the same cycle on the same register:
- The value is written.
- Dispatch wins the mapping: busy stays 1 and tag takes the new value.

Flush, when rdy_in=1 and flush_in=1:
- All busy bits clear and all tags become ROB_TAG_NONE.
- A same-cycle commit value is still written, because ROB commits JAL/JALR together with flush.
- A same-cycle dispatch is discarded.

Writes to x0 are ignored. Reads of x0 return busy=0, tag=0, data=0.

Lookups are combinational from current state:
- If busy: busy=1, tag=tag[rs], data=`NULL.
- Otherwise: busy=0, tag=0, data=value[rs].
- Lookups see pre-edge state. When rs equals rd in the same dispatch (e.g. addi x5,x5,1), the old mapping is returned.

## Timing
- Lookup latency is 0 cycles (combinational).
- Commit, dispatch and flush effects become visible one cycle after the edge.
- During reset (rst_in=0) every value is 0 and every busy/tag is 0. All outputs therefore read busy=0, tag=0, data=0.
- Reset asserted mid-operation overrides any in-progress commit, dispatch or flush.
- rdy_in=0 freezes state even if flush_in, commit or dispatch is asserted. Those requests are lost, and the upstream blocks hold them.

## Configuration
- REGFILE_COMMIT_BYPASS_EN defined:
  - A lookup with busy[rs]=1, rob_commit_en_in=1, rob_commit_reg_pos_in=rs and rob_commit_dest_in=tag[rs] returns busy=0, tag=0, data=rob_commit_value_in in the same cycle.
  - This closes the commit-vs-dispatch race.
- Not defined:
  - The lookup returns busy=1 with the tag.
  - The ROB's own dispatcher_rs*_rdy forwarding resolves the value.

## Structure
- Shared include define.vh holds `REGISTER_WIDTH (4:0), `ROB_WIDTH (4:0), `INSTRUCTION_WIDTH (31:0), `NULL, `ENABLE/`DISABLE, `BUSY/`IDLE.
- ROB_TAG_NONE belongs in define.vh as a shared constant, since the ROB also treats 0 as the unused index.
- Sub-module regfile_read_port handles x0, busy and bypass selection for one source register. It is instantiated twice, for rs1 and rs2.

## Test plan
1. Reset, then look up rs1=x7 → busy=0, tag=0, data=0. Commit x7=0x1234 with dest=3 → next cycle data=0x1234.
2. Dispatch rd=x5, dest=4; next cycle look up x5 → busy=1, tag=4. Commit reg=x5, dest=4, value=0xAA → next cycle busy=0, data=0xAA.
3. Dispatch x5 with dest=4, then x5 with dest=6. Commit x5 with dest=4, value=1 → value=1, busy=1, tag=6 retained.
4. Same cycle: commit x5 with dest=4 and dispatch x5 with dest=9 → busy=1, tag=9, value written.
5. Busy x3/x4 plus flush_in=1 with commit x1 (JAL link 0x104) → all busy cleared, x1=0x104. Same-cycle dispatch x8 with dest=2 is discarded.
6. With REGFILE_COMMIT_BYPASS_EN, commit x5 with dest=4, value=0x55 while looking up x5 → busy=0, data=0x55 in the same cycle. Without the macro → busy=1, tag=4. In both builds, rd=x0 dispatch and commit leave x0 at 0.
